fetch_datapath: RTL
===================

FETCH_DATAPATH -- requirements
Module: fetch_datapath

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 pcen  input  1  PC write enable from controller.
REQ-005 irwrite  input  1  instruction-register write enable.
REQ-006 iord  input  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-007 pcsrc  input  2  next-PC select.
REQ-008 aluresult  input  32  combinational ALU result.
REQ-009 readdata  input  32  memory read data.
REQ-010 adr  output  32  memory address.
REQ-011 pc  output  32  current PC register.
REQ-012 instr  output  32  instruction register.
REQ-013 data  output  32  memory data register (MDR).
REQ-014 aluout  output  32  ALUOut register.
REQ-015 op  output  6  instr[31:26] when instr_valid, else 0.
REQ-016 funct  output  6  instr[5:0] when instr_valid, else 0.
REQ-017 instr_valid  output  1  high once an instruction has been latched since reset.
REQ-018 instr_count  output  32  count of irwrite cycles since reset.

Function
REQ-019 adr SHALL be combinational: iord=0 -> pc, iord=1 -> aluout.
REQ-020 pcnext SHALL be: pcsrc 00 -> aluresult; 01 -> aluout; 10 -> {pc[31:28], instr[25:0], 2'b00}; 11 -> pc.
REQ-021 pc SHALL load pcnext on posedge clk when pcen=1, else hold.
REQ-022 instr SHALL load readdata on posedge clk when irwrite=1, else hold.
REQ-023 data and aluout SHALL load readdata and aluresult on every posedge clk (no enable).
REQ-024 Latency: every register output reflects inputs sampled at the preceding edge; there is no combinational path from an input to pc, instr, data or aluout.
REQ-025 instr_valid state machine: EMPTY -> VALID on the first irwrite=1 edge; VALID -> EMPTY only on reset.
REQ-026 instr_count SHALL increment by 1 on each edge with irwrite=1, wrapping from 32'hFFFF_FFFF to 0.
REQ-027 When pcen=1 and irwrite=1 in the same cycle, both registers SHALL update; instr SHALL capture readdata addressed by the pre-edge pc.
REQ-028 pcsrc=10 SHALL use the pre-edge pc and instr values.

Reset
REQ-029 On a posedge with reset=0: pc <= RESET_PC; instr, data, aluout, instr_count <= 0; instr_valid <= 0. Reset overrides pcen and irwrite.
REQ-030 Reset asserted mid-instruction SHALL discard all state; the first cycle after deassertion fetches from RESET_PC.

Configuration
REQ-031 Macro FETCH_JUMP_EN: when defined, pcsrc=10 selects the jump target per REQ-020.
REQ-032 When FETCH_JUMP_EN is undefined, pcsrc=10 SHALL behave as pcsrc=11 (PC holds), and the jump-target logic SHALL be absent.

Structure
REQ-033 A shared package SHALL hold the pcsrc encodings (PCSRC_ALU=00, PCSRC_ALUOUT=01, PCSRC_JUMP=10, PCSRC_HOLD=11) and the default RESET_PC.
REQ-034 One sub-module, flopenr (parameterised-width enable register with synchronous active-low reset), SHALL implement pc and instr.

Verification
REQ-035 The bench SHALL drive reset=0 for 1 edge with RESET_PC=0 -> pc=0, instr=0, instr_count=0, instr_valid=0, op=0.
REQ-036 The bench SHALL drive iord=0, pcen=1, irwrite=1, pcsrc=00, aluresult=4, readdata=32'h2008_0005 -> after the edge: pc=4, instr=32'h2008_0005, op=6'h08, instr_valid=1, instr_count=1.
REQ-037 The bench SHALL drive aluresult=32'h10, then iord=1 on the following cycle -> adr=32'h10; data equals readdata from the prior edge.
REQ-038 The bench SHALL drive pc=32'h4000_0004, instr=32'h0800_0010, pcsrc=10, pcen=1 -> with FETCH_JUMP_EN: pc=32'h4000_0040; without it: pc=32'h4000_0004.
REQ-039 The bench SHALL preset instr_count=32'hFFFF_FFFF and drive irwrite=1 -> instr_count=0.
REQ-040 The bench SHALL drive reset=0 in the same cycle as pcen=1 and irwrite=1 -> pc=RESET_PC and instr=0.

Source files
------------

// File: rtl/fetch_datapath_pkg.sv
// Shared definitions for the multicycle fetch datapath: next-PC select
// encodings, instruction-register fill state and the default reset PC.
package fetch_datapath_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_HOLD   = 2'b11
    } pcsrc_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_VALID = 1'b1
    } fill_state_e;

endpackage

// File: rtl/fetch_datapath_flopenr.sv
// Parameterised-width enable register with synchronous active-low reset;
// holds the PC and the instruction register.
module flopenr #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    always_comb begin
        q_d = q_q;
        if (en) q_d = d;
    end

    always_ff @(posedge clk) begin
        if (!reset) q_q <= RESET_VAL;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/fetch_datapath.sv
// Multicycle fetch datapath: PC, IR, MDR and ALUOut registers plus address
// and next-PC muxing. Define FETCH_JUMP_EN to enable the pcsrc=10 jump target.
module fetch_datapath
    import fetch_datapath_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcen,
    input  logic        irwrite,
    input  logic        iord,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] aluresult,
    input  logic [31:0] readdata,
    output logic [31:0] adr,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [31:0] data,
    output logic [31:0] aluout,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] instr_count
);

    logic [31:0] pcnext;
    logic [31:0] data_d, data_q;
    logic [31:0] aluout_d, aluout_q;
    logic [31:0] instr_count_d, instr_count_q;
    fill_state_e state_q;
    logic        instr_valid_q;

    // Jump target splices the pre-edge PC region with the IR's 26-bit index.
    always_comb begin
        pcnext = pc;
        case (pcsrc_e'(pcsrc))
            PCSRC_ALU:    pcnext = aluresult;
            PCSRC_ALUOUT: pcnext = aluout_q;
`ifdef FETCH_JUMP_EN
            PCSRC_JUMP:   pcnext = {pc[31:28], instr[25:0], 2'b00};
`endif
            default:      pcnext = pc;
        endcase
    end

    flopenr #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (pcen),
        .d     (pcnext),
        .q     (pc)
    );

    flopenr #(.WIDTH(32), .RESET_VAL(32'h0)) u_instr_reg (
        .clk   (clk),
        .reset (reset),
        .en    (irwrite),
        .d     (readdata),
        .q     (instr)
    );

    always_comb begin
        data_d        = readdata;
        aluout_d      = aluresult;
        instr_count_d = instr_count_q;
        if (irwrite) instr_count_d = instr_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q        <= '0;
            aluout_q      <= '0;
            instr_count_q <= '0;
        end else begin
            data_q        <= data_d;
            aluout_q      <= aluout_d;
            instr_count_q <= instr_count_d;
        end
    end

    // IR fill tracker: leaves EMPTY on the first IR write, only reset returns it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_EMPTY;
            instr_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: if (irwrite) begin
                    state_q       <= ST_VALID;
                    instr_valid_q <= 1'b1;
                end
                default: begin
                    state_q       <= ST_VALID;
                    instr_valid_q <= 1'b1;
                end
            endcase
        end
    end

    assign adr         = iord ? aluout_q : pc;
    assign data        = data_q;
    assign aluout      = aluout_q;
    assign instr_valid = instr_valid_q;
    assign instr_count = instr_count_q;
    assign op          = instr_valid_q ? instr[31:26] : 6'd0;
    assign funct       = instr_valid_q ? instr[5:0]   : 6'd0;

endmodule
